// File: rtl/audio_playback_sequencer.sv
// Playback sequencer: walks a circular window of the sample RAM through port 2 and
// streams stereo pairs over valid/ready. Avalon-MM CSR slave with half/done interrupt.
module audio_playback_sequencer #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        csr_address,
   input  logic              csr_write,
   input  logic [31:0]       csr_writedata,
   input  logic              csr_read,
   output logic [31:0]       csr_readdata,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_clken,
   output logic              ram_write,
   output logic [3:0]        ram_byteenable,
   input  logic [DATA_W-1:0] ram_readdata,
   output logic              sample_valid,
   input  logic              sample_ready,
   output logic [15:0]       sample_left,
   output logic [15:0]       sample_right,
   output logic              irq
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_START  = 3'd1;
   localparam logic [2:0] A_END    = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_POS    = 3'd4;

   typedef struct packed {
      logic irq_en;
      logic loop;
      logic run;
   } ctrl_t;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PRESENT} state_t;

   state_t            state, state_nxt;
   ctrl_t             ctrl, ctrl_w, ctrl_nxt;
   logic [ADDR_W-1:0] start_r, end_r;
   logic [ADDR_W-1:0] sh_start, sh_end, sh_mid;
   logic [ADDR_W-1:0] ptr, ptr_nxt;
   logic [ADDR_W-1:0] win_span;
   logic              half, done;
   logic              hw_half, hw_done, hw_stop;
   logic [15:0]       smp_l, smp_r;
   logic [31:0]       rd_mux;
   logic              wr_ctrl, wr_start, wr_end, wr_stat;
   logic              run_rise, busy;
   logic              unused_wdata;

   assign wr_ctrl  = csr_write && (csr_address == A_CTRL);
   assign wr_start = csr_write && (csr_address == A_START);
   assign wr_end   = csr_write && (csr_address == A_END);
   assign wr_stat  = csr_write && (csr_address == A_STATUS);

   assign ctrl_w   = wr_ctrl ? ctrl_t'(csr_writedata[2:0]) : ctrl;
   assign run_rise = ctrl_w.run && !ctrl.run;
   assign win_span = end_r - start_r;
   assign busy     = (state != S_IDLE);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hw_half   = 1'b0;
      hw_done   = 1'b0;
      hw_stop   = 1'b0;
      case (state)
         S_IDLE: begin
            // a run that was set while still draining is honoured without a new edge
            if (ctrl_w.run) begin
               state_nxt = S_FETCH;
               ptr_nxt   = run_rise ? start_r : sh_start;
            end
         end
         S_FETCH: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_PRESENT;
         S_PRESENT: begin
            if (sample_ready) begin
               hw_half = (ptr == sh_mid);
               if (ptr == sh_end) begin
                  hw_done = 1'b1;
                  if (ctrl.loop && ctrl.run) begin
                     ptr_nxt   = sh_start;
                     state_nxt = S_FETCH;
                  end else begin
                     hw_stop   = 1'b1;
                     state_nxt = S_IDLE;
                  end
               end else if (ctrl.run) begin
                  ptr_nxt   = ptr + 1'b1;
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ctrl_nxt = ctrl_w;
      // a CPU write of CONTROL in the same cycle keeps its run value
      if (hw_stop && !wr_ctrl) ctrl_nxt.run = 1'b0;
   end

   always_comb begin
      rd_mux = '0;
      case (csr_address)
         A_CTRL:   rd_mux[2:0]        = ctrl;
         A_START:  rd_mux[ADDR_W-1:0] = start_r;
         A_END:    rd_mux[ADDR_W-1:0] = end_r;
         A_STATUS: rd_mux[2:0]        = {done, half, busy};
         A_POS:    rd_mux[ADDR_W-1:0] = ptr;
         default:  rd_mux             = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         ptr          <= '0;
         ctrl         <= '0;
         start_r      <= '0;
         end_r        <= '0;
         sh_start     <= '0;
         sh_end       <= '0;
         sh_mid       <= '0;
         half         <= 1'b0;
         done         <= 1'b0;
         smp_l        <= '0;
         smp_r        <= '0;
         csr_readdata <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         ctrl  <= ctrl_nxt;
         if (wr_start) start_r <= csr_writedata[ADDR_W-1:0];
         if (wr_end)   end_r   <= csr_writedata[ADDR_W-1:0];
         if (run_rise) begin
            sh_start <= start_r;
            sh_end   <= end_r;
            sh_mid   <= start_r + (win_span >> 1);
         end
         // hardware set beats a simultaneous write-one-to-clear
         half <= hw_half | (half & ~(wr_stat & csr_writedata[1]));
         done <= hw_done | (done & ~(wr_stat & csr_writedata[2]));
         if (state == S_WAIT) begin
            smp_l <= ram_readdata[DATA_W-1 -: 16];
            smp_r <= ram_readdata[15:0];
         end
         if (csr_read) csr_readdata <= rd_mux;
      end
   end

   assign ram_address    = ptr;
   assign ram_chipselect = (state == S_FETCH);
   assign ram_clken      = 1'b1;
   assign ram_write      = 1'b0;
   assign ram_byteenable = 4'hF;
   assign sample_valid   = (state == S_PRESENT);
   assign sample_left    = smp_l;
   assign sample_right   = smp_r;
   assign irq            = ctrl.irq_en & (half | done);

   assign unused_wdata = &{1'b0, csr_writedata[31:ADDR_W], 1'b0};

endmodule

// File: tb/tb_audio_playback_sequencer.sv
// Bench for audio_playback_sequencer: CSR vector table, directed corner sequences and
// randomized windows checked against a window-walk model over a RAM image.
module tb_audio_playback_sequencer;
   localparam int MASK = 8191;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  csr_address;
   logic        csr_write;
   logic [31:0] csr_writedata;
   logic        csr_read;
   logic [31:0] csr_readdata;
   logic [12:0] ram_address;
   logic        ram_chipselect;
   logic        ram_clken;
   logic        ram_write;
   logic [3:0]  ram_byteenable;
   logic [31:0] ram_readdata;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] sample_left;
   logic [15:0] sample_right;
   logic        irq;

   always #5 clk = ~clk;

   audio_playback_sequencer #(.ADDR_W(13), .DATA_W(32)) dut (
      .clk(clk), .reset_n(reset_n),
      .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
      .csr_read(csr_read), .csr_readdata(csr_readdata),
      .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_clken(ram_clken),
      .ram_write(ram_write), .ram_byteenable(ram_byteenable), .ram_readdata(ram_readdata),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .sample_left(sample_left), .sample_right(sample_right), .irq(irq)
   );

   // RAM port 2 image: address registered on the FETCH edge, data readable in WAIT
   logic [31:0] mem [0:8191];
   logic [31:0] ram_q;
   always @(posedge clk) if (ram_chipselect) ram_q <= mem[ram_address];
   assign ram_readdata = ram_q;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [31:0] acc_data [0:4095];
   int          acc_cyc  [0:4095];
   int          acc_n = 0;
   logic [12:0] fet_addr [0:4095];
   int          fet_n = 0;
   int          irq_rise_cyc = -1;
   logic        prev_irq = 1'b0;
   int          base_a, base_f, s, len, e;
   logic [31:0] rd;

   typedef struct {
      logic [2:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } csr_vec_t;
   csr_vec_t vec [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // one clock: log handshakes and fetches, check that a stalled sample is held
   task automatic tick();
      logic pv, pr, pc;
      logic [12:0] pa;
      logic [31:0] pd;
      pv = sample_valid; pr = sample_ready; pc = ram_chipselect;
      pa = ram_address;  pd = {sample_left, sample_right};
      @(posedge clk); #2;
      cyc++;
      if (pv && pr && acc_n < 4096) begin
         acc_data[acc_n] = pd; acc_cyc[acc_n] = cyc; acc_n++;
      end
      if (pc && fet_n < 4096) begin
         fet_addr[fet_n] = pa; fet_n++;
      end
      if (pv && !pr && reset_n) begin
         chk("hold_valid", {31'd0, sample_valid}, 32'd1);
         chk("hold_data", {sample_left, sample_right}, pd);
         chk("hold_no_fetch", {31'd0, ram_chipselect}, 32'd0);
      end
      if (irq && !prev_irq) irq_rise_cyc = cyc;
      prev_irq = irq;
   endtask

   task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
      csr_address = a; csr_writedata = d; csr_write = 1'b1;
      tick();
      csr_write = 1'b0;
   endtask

   task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
      csr_address = a; csr_read = 1'b1;
      tick();
      csr_read = 1'b0;
      d = csr_readdata;
   endtask

   task automatic wait_acc(input int target, input int budget, input bit rnd);
      int k;
      k = 0;
      while (acc_n < target && k < budget) begin
         if (rnd) sample_ready = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      chk("wait_acc_in_time", {31'd0, acc_n >= target}, 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int k;
      k = 0;
      while (!sample_valid && k < budget) begin
         tick();
         k++;
      end
      chk("wait_valid_in_time", {31'd0, sample_valid}, 32'd1);
   endtask

   task automatic start_play(input int st, input int en, input logic [2:0] c);
      csr_wr(3'd1, st);
      csr_wr(3'd2, en);
      csr_wr(3'd0, {29'd0, c});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; csr_address = '0; csr_write = 1'b0; csr_writedata = '0;
      csr_read = 1'b0; sample_ready = 1'b0;
      for (int i = 0; i < 8192; i++) mem[i] = $urandom;
      for (int i = 0; i < 4; i++) mem[10 + i] = 32'h0001_0002 + i * 32'h0002_0002;

      vec[0] = '{3'd0, 1'b1, 32'h0000_0006, 32'h0000_0006};
      vec[1] = '{3'd1, 1'b1, 32'hFFFF_FFFF, 32'h0000_1FFF};
      vec[2] = '{3'd2, 1'b1, 32'h0001_2345, 32'h0000_0345};
      vec[3] = '{3'd3, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      vec[4] = '{3'd4, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      vec[5] = '{3'd5, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      vec[6] = '{3'd6, 1'b0, 32'h0000_0000, 32'h0000_0000};
      vec[7] = '{3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000};
      vec[8] = '{3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
      vec[9] = '{3'd1, 1'b1, 32'h0000_0000, 32'h0000_0000};

      // reset state
      repeat (3) @(posedge clk);
      #2;
      chk("rst_valid", {31'd0, sample_valid}, 32'd0);
      chk("rst_cs", {31'd0, ram_chipselect}, 32'd0);
      chk("rst_clken", {31'd0, ram_clken}, 32'd1);
      chk("rst_write", {31'd0, ram_write}, 32'd0);
      chk("rst_be", {28'd0, ram_byteenable}, 32'hF);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_addr", {19'd0, ram_address}, 32'd0);
      chk("rst_rdata", csr_readdata, 32'd0);
      reset_n = 1'b1;
      tick();
      for (int a = 0; a < 8; a++) begin
         csr_rd(3'(a), rd);
         chk($sformatf("rst_csr%0d", a), rd, 32'd0);
      end

      // CSR access table
      for (int i = 0; i < 10; i++) begin
         if (vec[i].wr) csr_wr(vec[i].addr, vec[i].wdata);
         csr_rd(vec[i].addr, rd);
         chk($sformatf("csr_vec%0d", i), rd, vec[i].exp);
      end
      chk("csr_no_fetch", fet_n, 32'd0);

      // basic playback, first-sample latency, half irq timing
      sample_ready = 1'b1;
      base_a = acc_n; base_f = fet_n; irq_rise_cyc = -1;
      csr_wr(3'd1, 10);
      csr_wr(3'd2, 13);
      csr_wr(3'd0, 5);
      chk("t1_cs", {31'd0, ram_chipselect}, 32'd1);
      chk("t1_addr", {19'd0, ram_address}, 32'd10);
      chk("t1_valid", {31'd0, sample_valid}, 32'd0);
      tick();
      chk("t2_valid", {31'd0, sample_valid}, 32'd0);
      tick();
      chk("t3_valid", {31'd0, sample_valid}, 32'd1);
      chk("t3_data", {sample_left, sample_right}, 32'h0001_0002);
      wait_acc(base_a + 4, 40, 1'b0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("basic_s%0d", i), acc_data[base_a + i], 32'h0001_0002 + i * 32'h0002_0002);
      chk("basic_half_irq_cyc", irq_rise_cyc, acc_cyc[base_a + 1]);
      repeat (3) tick();
      chk("basic_fetches", fet_n - base_f, 32'd4);
      csr_rd(3'd3, rd); chk("basic_status", rd, 32'd6);
      csr_rd(3'd0, rd); chk("basic_ctrl", rd, 32'd4);
      csr_wr(3'd3, 2);
      csr_rd(3'd3, rd); chk("w1c_half_status", rd, 32'd4);
      chk("w1c_half_irq", {31'd0, irq}, 32'd1);
      csr_wr(3'd3, 4);
      csr_rd(3'd3, rd); chk("w1c_done_status", rd, 32'd0);
      chk("w1c_done_irq", {31'd0, irq}, 32'd0);

      // backpressure on sample 2
      base_a = acc_n; base_f = fet_n;
      start_play(20, 23, 3'd1);
      wait_acc(base_a + 1, 40, 1'b0);
      sample_ready = 1'b0;
      wait_valid(10);
      chk("bp_data", {sample_left, sample_right}, mem[21]);
      repeat (10) tick();
      chk("bp_fetches_held", fet_n - base_f, 32'd2);
      sample_ready = 1'b1;
      wait_acc(base_a + 4, 40, 1'b0);
      for (int i = 0; i < 4; i++)
         chk($sformatf("bp_s%0d", i), acc_data[base_a + i], mem[20 + i]);
      repeat (3) tick();
      csr_wr(3'd3, 6);

      // wrap through 8191->0 with loop, then stop
      base_a = acc_n; base_f = fet_n; irq_rise_cyc = -1;
      start_play(8190, 1, 3'd7);
      wait_acc(base_a + 10, 60, 1'b0);
      csr_wr(3'd0, 6);
      repeat (12) tick();
      chk("loop_min_samples", {31'd0, (acc_n - base_a) >= 10}, 32'd1);
      chk("loop_fetch_eq_acc", fet_n - base_f, acc_n - base_a);
      for (int i = 0; i < acc_n - base_a; i++) begin
         chk($sformatf("loop_addr%0d", i), {19'd0, fet_addr[base_f + i]}, (8190 + i % 4) & MASK);
         chk($sformatf("loop_s%0d", i), acc_data[base_a + i], mem[(8190 + i % 4) & MASK]);
      end
      chk("loop_mid_irq_cyc", irq_rise_cyc, acc_cyc[base_a + 1]);
      csr_rd(3'd3, rd); chk("loop_status", rd, 32'd6);
      csr_wr(3'd3, 6);

      // stop while addr 12 is presented
      base_a = acc_n; base_f = fet_n;
      start_play(10, 13, 3'd5);
      wait_acc(base_a + 2, 40, 1'b0);
      sample_ready = 1'b0;
      wait_valid(10);
      chk("stop_data", {sample_left, sample_right}, 32'h0005_0006);
      csr_rd(3'd4, rd); chk("stop_position", rd, 32'd12);
      csr_wr(3'd0, 4);
      sample_ready = 1'b1;
      repeat (8) tick();
      chk("stop_samples", acc_n - base_a, 32'd3);
      chk("stop_fetches", fet_n - base_f, 32'd3);
      csr_rd(3'd3, rd); chk("stop_status", rd, 32'd2);
      csr_rd(3'd0, rd); chk("stop_ctrl", rd, 32'd4);
      chk("stop_irq", {31'd0, irq}, 32'd1);
      csr_wr(3'd3, 6);

      // W1C of done in the same cycle the hardware sets it
      base_a = acc_n;
      start_play(10, 13, 3'd5);
      wait_acc(base_a + 3, 40, 1'b0);
      sample_ready = 1'b0;
      wait_valid(10);
      chk("race_data", {sample_left, sample_right}, 32'h0007_0008);
      csr_wr(3'd3, 2);
      chk("race_pre_irq", {31'd0, irq}, 32'd0);
      sample_ready = 1'b1;
      csr_wr(3'd3, 4);
      chk("race_irq", {31'd0, irq}, 32'd1);
      chk("race_samples", acc_n - base_a, 32'd4);
      csr_rd(3'd3, rd); chk("race_status", rd, 32'd4);
      csr_wr(3'd3, 4);
      chk("race_clr_irq", {31'd0, irq}, 32'd0);
      csr_rd(3'd3, rd); chk("race_clr_status", rd, 32'd0);

      // reset in PRESENT
      base_a = acc_n;
      start_play(10, 13, 3'd5);
      wait_acc(base_a + 2, 40, 1'b0);
      sample_ready = 1'b0;
      wait_valid(10);
      csr_rd(3'd0, rd); chk("prerst_ctrl", rd, 32'd5);
      chk("prerst_irq", {31'd0, irq}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("mrst_valid", {31'd0, sample_valid}, 32'd0);
      chk("mrst_cs", {31'd0, ram_chipselect}, 32'd0);
      chk("mrst_irq", {31'd0, irq}, 32'd0);
      chk("mrst_rdata", csr_readdata, 32'd0);
      chk("mrst_sample", {sample_left, sample_right}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();
      for (int a = 0; a < 8; a++) begin
         csr_rd(3'(a), rd);
         chk($sformatf("mrst_csr%0d", a), rd, 32'd0);
      end
      sample_ready = 1'b1;
      base_a = acc_n; base_f = fet_n;
      repeat (6) tick();
      chk("mrst_idle_fetch", fet_n - base_f, 32'd0);
      chk("mrst_idle_valid", {31'd0, sample_valid}, 32'd0);
      start_play(10, 13, 3'd1);
      wait_acc(base_a + 4, 40, 1'b0);
      chk("mrst_restart_s0", acc_data[base_a], 32'h0001_0002);
      repeat (3) tick();
      csr_wr(3'd3, 6);

      // randomized windows with random backpressure
      for (int it = 0; it < 20; it++) begin
         s   = $urandom_range(0, MASK);
         len = $urandom_range(1, 12);
         e   = (s + len - 1) & MASK;
         for (int i = 0; i < len; i++) mem[(s + i) & MASK] = $urandom;
         base_a = acc_n; base_f = fet_n;
         start_play(s, e, 3'd1);
         wait_acc(base_a + len, 400, 1'b1);
         sample_ready = 1'b1;
         repeat (6) tick();
         chk($sformatf("rnd%0d_samples", it), acc_n - base_a, len);
         chk($sformatf("rnd%0d_fetches", it), fet_n - base_f, len);
         for (int i = 0; i < len && i < acc_n - base_a; i++)
            chk($sformatf("rnd%0d_s%0d", it, i), acc_data[base_a + i], mem[(s + i) & MASK]);
         csr_rd(3'd3, rd); chk($sformatf("rnd%0d_status", it), rd, 32'd6);
         csr_wr(3'd3, 6);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/audio_playback_sequencer.md
# audio_playback_sequencer

Playback sequencer for the dual-port audio sample RAM (8192 x 32). Owns the RAM's second port as a read-only master: it walks a CPU-programmed circular window of sample words and streams them as stereo 16-bit pairs to the codec output path over a valid/ready handshake. The CPU fills the RAM through the first port and controls the sequencer through a small Avalon-MM CSR slave. An interrupt is raised at half-window and end-of-window.

## Interface
- ADDR_W, 13, RAM word-address width (8192 words)
- DATA_W, 32, RAM word width; [31:16] = left sample, [15:0] = right sample
- clk  in  1  sole clock; RAM port 2 and CSR are on this clock
- reset_n  in  1  asynchronous, active-low reset
- csr_address  in  3  CSR word select
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  registered; valid the cycle after csr_read
- ram_address  out  ADDR_W  RAM port 2 address
- ram_chipselect  out  1  high only in FETCH
- ram_clken  out  1  tied 1
- ram_write  out  1  tied 0
- ram_byteenable  out  4  tied 4'hF
- ram_readdata  in  DATA_W  valid one cycle after address registered
- sample_valid  out  1  stereo sample available
- sample_ready  in  1  sink accepts sample
- sample_left  out  16  left sample
- sample_right  out  16  right sample
- irq  out  1  level interrupt

## Operation
- CSR map:
  - 0 CONTROL (RW): bit0 run, bit1 loop, bit2 irq_en.
  - 1 START (RW, [12:0]).
  - 2 END (RW, inclusive, [12:0]).
  - 3 STATUS: bit0 busy (RO); bit1 half (W1C); bit2 done (W1C).
  - 4 POSITION (RO): current pointer.
  - Unmapped addresses read 0.
- START/END are latched into shadow registers on the 0->1 edge of run. Writes during playback affect the next start only.
- Pointer arithmetic is modulo 2^ADDR_W; END < START wraps through 8191->0.
- len = (END-START mod 8192)+1.
- mid = START + ((len-1)>>1) mod 8192.
- FSM:
  - IDLE: run=1 -> FETCH with ptr=START.
  - FETCH: drive ram_address=ptr, ram_chipselect=1 -> WAIT.
  - WAIT: capture ram_readdata into sample_left/right -> PRESENT.
  - PRESENT: sample_valid=1. On valid&ready:
    - ptr==mid: set half.
    - ptr==END: set done. If loop=1 and run=1, ptr=START -> FETCH; else clear run -> IDLE.
    - Otherwise ptr+1 -> FETCH, or -> IDLE if run=0.
- Stop: clearing run mid-playback takes effect at the next sample boundary. The presented sample stays valid, unchanged, until accepted. No sample is ever withdrawn.
- busy = (state != IDLE).
- irq = irq_en & (half | done).
- A hardware set and a CSR W1C of the same flag in the same cycle: set wins.
- Output data is stable while sample_valid=1 and sample_ready=0.

## Timing
- Reset (async assert, sync deassert handled upstream): every output 0 except ram_clken=1 and ram_byteenable=4'hF; state IDLE; all CSRs 0.
- run written in cycle T:
  - FETCH in T+1.
  - WAIT in T+2.
  - sample_valid=1 from T+3.
- Steady state with sample_ready held high: one sample every 3 cycles (FETCH, WAIT, PRESENT). This is ample for 48 kHz at the 50 MHz system clock.
- half/done set in the cycle after the accepting handshake; irq follows in the same cycle.
- csr_readdata: one-cycle latency. POSITION returns the pointer at the csr_read cycle.

## Test plan
- Basic playback: RAM[10..13] = 32'h0001_0002 .. 32'h0007_0008, START=10, END=13, loop=0, run=1, ready=1.
  - Expect 4 samples: (1,2),(3,4),(5,6),(7,8).
  - First valid 3 cycles after the run write.
  - half set after sample 2 (addr 11); done after sample 4.
  - run and busy read 0 afterwards.
- Backpressure: hold ready=0 for 10 cycles on sample 2 -> valid stays 1 with data unchanged; no further RAM fetch occurs (ram_chipselect stays 0).
- Wrap and loop: START=8190, END=1, loop=1 -> address sequence 8190,8191,0,1,8190,...; done pulses set once per pass; mid=8191.
- Mid-play stop: clear run while sample at addr 12 is presented -> that sample completes its handshake, then IDLE; no further fetch; done not set.
- IRQ/W1C race: irq_en=1; write STATUS=3'b100 in the same cycle the hardware sets done -> done stays 1 and irq stays 1; a later W1C clears both.
- Reset mid-play: assert reset_n=0 in PRESENT -> sample_valid, ram_chipselect, irq and all CSRs read 0 immediately; after release, the block is IDLE until run is written again.
